// File: rtl/seq_gen_pkg.sv
// Package for the 10010 serial pattern generator.
// Holds the FSM state encoding, the default pattern constants and the
// counter widths shared by sequence_gen_10010.
package seq_gen_pkg;

   // Default pattern is 5'b10010, zero-extended into an 8-bit container.
   // PAT_LEN selects how many of the low bits are used, MSB first.
   localparam logic [7:0] DEF_PATTERN = 8'b0001_0010;
   localparam int         DEF_PAT_LEN = 5;
   localparam int         DEF_OVL_LEN = 2;

   localparam int IDX_W = 3;   // bit index 0..7
   localparam int GAP_W = 4;   // gap counter 0..15
   localparam int CNT_W = 8;   // instance counter, no wrap at 255

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/sequence_gen_10010.sv
// Serial pattern generator.
// Emits PATTERN (PAT_LEN bits, MSB first) repeat_cnt times per frame,
// either as an overlapping stream (consecutive instances share OVL_LEN
// bits) or as full instances separated by GAP_CYC idle cycles.
// Ports:
//   clk        - clock, all logic on rising edge
//   rst_n      - synchronous active-low reset
//   start      - frame request, accepted only in IDLE/DONE
//   repeat_cnt - instances per frame (0 behaves as 1), latched on start
//   overlap    - 1 = overlapping stream, latched on start
//   abort      - ends an active frame without a done pulse
//   data_out   - serial bit stream (registered)
//   data_valid - data_out carries a pattern bit (registered)
//   pat_end    - pulse on the last bit of every instance (registered)
//   busy       - frame in progress, bits or gap (registered)
//   done       - pulse the cycle after a completed frame (registered)
module sequence_gen_10010
   import seq_gen_pkg::*;
#(
   parameter logic [7:0] PATTERN    = DEF_PATTERN,
   parameter int         PAT_LEN    = DEF_PAT_LEN,
   parameter int         OVL_LEN    = DEF_OVL_LEN,
   parameter int         GAP_CYC    = 1,
   parameter logic       IDLE_LEVEL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic             overlap,
   input  logic             abort,
   output logic             data_out,
   output logic             data_valid,
   output logic             pat_end,
   output logic             busy,
   output logic             done
);

   // First index of a full instance, and the index where an overlapping
   // instance resumes (its first OVL_LEN bits were already sent).
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(PAT_LEN - 1);
   localparam logic [IDX_W-1:0] IDX_OVL  = IDX_W'(PAT_LEN - 1 - OVL_LEN);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);

   state_t           state_q,      state_d;
   logic [IDX_W-1:0] bit_idx_q,    bit_idx_d;
   logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;
   logic [CNT_W-1:0] inst_rem_q,   inst_rem_d;   // instances left after the current one
   logic             ovl_q,        ovl_d;
   logic             data_out_q,   data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             pat_end_q,    pat_end_d;
   logic             busy_q,       busy_d;
   logic             done_q,       done_d;

   logic             emit;
   logic [IDX_W-1:0] emit_idx;

   always_comb begin
      state_d      = state_q;
      bit_idx_d    = bit_idx_q;
      gap_cnt_d    = gap_cnt_q;
      inst_rem_d   = inst_rem_q;
      ovl_d        = ovl_q;
      data_out_d   = IDLE_LEVEL;
      data_valid_d = 1'b0;
      pat_end_d    = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      emit         = 1'b0;
      emit_idx     = IDX_FULL;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            // abort blocks a start only in IDLE; in DONE abort is simply ignored
            if (start && !(abort && state_q == ST_IDLE)) begin
               ovl_d      = overlap;
               inst_rem_d = (repeat_cnt == '0) ? '0 : repeat_cnt - 1'b1;
               emit       = 1'b1;
               emit_idx   = IDX_FULL;
            end
         end
         ST_SEND: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (bit_idx_q == '0) begin
               if (inst_rem_q == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  inst_rem_d = inst_rem_q - 1'b1;
                  if (ovl_q) begin
                     emit     = 1'b1;
                     emit_idx = IDX_OVL;
                  end else if (GAP_CYC > 0) begin
                     state_d   = ST_GAP;
                     gap_cnt_d = GAP_LOAD;
                     busy_d    = 1'b1;
                  end else begin
                     emit     = 1'b1;
                     emit_idx = IDX_FULL;
                  end
               end
            end else begin
               emit     = 1'b1;
               emit_idx = bit_idx_q - 1'b1;
            end
         end
         ST_GAP: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (gap_cnt_q == '0) begin
               emit     = 1'b1;
               emit_idx = IDX_FULL;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
               busy_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Every path that puts a pattern bit on the line funnels through here.
      if (emit) begin
         state_d      = ST_SEND;
         bit_idx_d    = emit_idx;
         data_out_d   = PATTERN[emit_idx];
         data_valid_d = 1'b1;
         busy_d       = 1'b1;
         pat_end_d    = (emit_idx == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         bit_idx_q    <= '0;
         gap_cnt_q    <= '0;
         inst_rem_q   <= '0;
         ovl_q        <= 1'b0;
         data_out_q   <= IDLE_LEVEL;
         data_valid_q <= 1'b0;
         pat_end_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_idx_q    <= bit_idx_d;
         gap_cnt_q    <= gap_cnt_d;
         inst_rem_q   <= inst_rem_d;
         ovl_q        <= ovl_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         pat_end_q    <= pat_end_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign pat_end    = pat_end_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_sequence_gen_10010.sv
// Directed bench for sequence_gen_10010 with default parameters
// (PATTERN 10010, PAT_LEN 5, OVL_LEN 2, GAP_CYC 1, IDLE_LEVEL 0).
// Expected output words are {data_out, data_valid, pat_end, busy, done}.
module tb_sequence_gen_10010;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] repeat_cnt;
   logic       overlap;
   logic       abort;
   logic       data_out, data_valid, pat_end, busy, done;

   int checks = 0;
   int errors = 0;

   sequence_gen_10010 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .repeat_cnt (repeat_cnt),
      .overlap    (overlap),
      .abort      (abort),
      .data_out   (data_out),
      .data_valid (data_valid),
      .pat_end    (pat_end),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock, then compare all five outputs.
   task automatic tc(input string tag, input logic [4:0] exp);
      logic [4:0] obs;
      tick();
      obs = {data_out, data_valid, pat_end, busy, done};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      int vcnt, pcnt, dseen;
      rst_n = 1'b0; start = 1'b0; repeat_cnt = 8'd0; overlap = 1'b0; abort = 1'b0;

      // Reset state
      tc("reset", 5'b00000);
      rst_n = 1'b1;
      tc("idle_after_reset", 5'b00000);

      // Single instance
      start = 1'b1; repeat_cnt = 8'd1; overlap = 1'b0;
      tc("t1_c1", 5'b11010);
      start = 1'b0;
      tc("t1_c2", 5'b01010);
      tc("t1_c3", 5'b01010);
      tc("t1_c4", 5'b11010);
      tc("t1_c5", 5'b01110);
      tc("t1_done", 5'b00001);
      tc("t1_idle", 5'b00000);

      // Two instances with one gap cycle
      start = 1'b1; repeat_cnt = 8'd2; overlap = 1'b0;
      tc("t2_c1", 5'b11010);
      start = 1'b0;
      tc("t2_c2", 5'b01010);
      tc("t2_c3", 5'b01010);
      tc("t2_c4", 5'b11010);
      tc("t2_c5", 5'b01110);
      tc("t2_gap", 5'b00010);
      tc("t2_c7", 5'b11010);
      tc("t2_c8", 5'b01010);
      tc("t2_c9", 5'b01010);
      tc("t2_c10", 5'b11010);
      tc("t2_c11", 5'b01110);
      tc("t2_done", 5'b00001);
      tc("t2_idle", 5'b00000);

      // Overlap, three instances; start with new settings while busy is ignored
      start = 1'b1; repeat_cnt = 8'd3; overlap = 1'b1;
      tc("t3_c1", 5'b11010);
      repeat_cnt = 8'd9; overlap = 1'b0;
      tc("t3_c2", 5'b01010);
      tc("t3_c3", 5'b01010);
      start = 1'b0;
      tc("t3_c4", 5'b11010);
      tc("t3_c5", 5'b01110);
      tc("t3_c6", 5'b01010);
      tc("t3_c7", 5'b11010);
      tc("t3_c8", 5'b01110);
      tc("t3_c9", 5'b01010);
      tc("t3_c10", 5'b11010);
      tc("t3_c11", 5'b01110);
      tc("t3_done", 5'b00001);
      tc("t3_idle", 5'b00000);

      // repeat_cnt=0 acts as 1; start held high gives back-to-back frames
      start = 1'b1; repeat_cnt = 8'd0; overlap = 1'b0;
      tc("t4_c1", 5'b11010);
      tc("t4_c2", 5'b01010);
      tc("t4_c3", 5'b01010);
      tc("t4_c4", 5'b11010);
      tc("t4_c5", 5'b01110);
      tc("t4_done1", 5'b00001);
      tc("t4_f2_c1", 5'b11010);
      tc("t4_f2_c2", 5'b01010);
      tc("t4_f2_c3", 5'b01010);
      tc("t4_f2_c4", 5'b11010);
      tc("t4_f2_c5", 5'b01110);
      start = 1'b0;
      tc("t4_done2", 5'b00001);
      tc("t4_idle", 5'b00000);

      // Abort on bit 3 of instance 2
      start = 1'b1; repeat_cnt = 8'd2; overlap = 1'b0;
      tc("t5_c1", 5'b11010);
      start = 1'b0;
      tc("t5_c2", 5'b01010);
      tc("t5_c3", 5'b01010);
      tc("t5_c4", 5'b11010);
      tc("t5_c5", 5'b01110);
      tc("t5_gap", 5'b00010);
      tc("t5_i2b1", 5'b11010);
      tc("t5_i2b2", 5'b01010);
      tc("t5_i2b3", 5'b01010);
      abort = 1'b1;
      tc("t5_aborted", 5'b00000);
      abort = 1'b0;
      tc("t5_no_done", 5'b00000);
      // start together with abort in IDLE is ignored
      start = 1'b1; abort = 1'b1; repeat_cnt = 8'd1;
      tc("t5_start_abort", 5'b00000);
      abort = 1'b0;
      tc("t5_new_c1", 5'b11010);
      start = 1'b0;
      tc("t5_new_c2", 5'b01010);
      tc("t5_new_c3", 5'b01010);
      tc("t5_new_c4", 5'b11010);
      tc("t5_new_c5", 5'b01110);
      tc("t5_new_done", 5'b00001);

      // Abort on the final bit wins over completion
      start = 1'b1; repeat_cnt = 8'd1;
      tc("t6_c1", 5'b11010);
      start = 1'b0;
      tc("t6_c2", 5'b01010);
      tc("t6_c3", 5'b01010);
      tc("t6_c4", 5'b11010);
      tc("t6_c5", 5'b01110);
      abort = 1'b1;
      tc("t6_abort_last", 5'b00000);
      abort = 1'b0;
      tc("t6_idle", 5'b00000);

      // Reset during the gap
      start = 1'b1; repeat_cnt = 8'd2;
      tc("t7_c1", 5'b11010);
      start = 1'b0;
      tc("t7_c2", 5'b01010);
      tc("t7_c3", 5'b01010);
      tc("t7_c4", 5'b11010);
      tc("t7_c5", 5'b01110);
      tc("t7_gap", 5'b00010);
      rst_n = 1'b0;
      tc("t7_reset", 5'b00000);
      rst_n = 1'b1;
      tc("t7_after1", 5'b00000);
      tc("t7_after2", 5'b00000);
      start = 1'b1; repeat_cnt = 8'd1;
      tc("t7_new_c1", 5'b11010);
      start = 1'b0;
      tc("t7_new_c2", 5'b01010);

      // 255 overlapping instances: 5 + 254*3 = 767 valid bits, 255 pat_end
      repeat (5) tick();
      start = 1'b1; repeat_cnt = 8'd255; overlap = 1'b1;
      tick();
      start = 1'b0;
      vcnt = 0; pcnt = 0; dseen = 0;
      for (int i = 0; i < 2000 && dseen == 0; i++) begin
         if (data_valid) vcnt++;
         if (pat_end) pcnt++;
         if (done) dseen = 1;
         if (dseen == 0) tick();
      end
      check_val("t8_done_seen", dseen, 1);
      check_val("t8_valid_bits", vcnt, 767);
      check_val("t8_pat_ends", pcnt, 255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sequence_gen_10010.md
SEQUENCE_GEN_10010 -- requirements
Module: sequence_gen_10010

Interface
REQ-001 Parameter PATTERN, default 5'b10010, bit pattern to emit, MSB first.
REQ-002 Parameter PAT_LEN, default 5, number of valid bits in PATTERN; legal range 2..8.
REQ-003 Parameter OVL_LEN, default 2, bits shared between consecutive instances in overlap mode; legal range 0..PAT_LEN-1.
REQ-004 Parameter GAP_CYC, default 1, idle cycles between instances in non-overlap mode; legal range 0..15.
REQ-005 Parameter IDLE_LEVEL, default 1'b0, data_out level whenever no pattern bit is driven.
REQ-006 clk  input  1  single clock; all logic on posedge clk.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 start  input  1  request; sampled only when FSM in IDLE or DONE.
REQ-009 repeat_cnt  input  8  number of pattern instances, latched on accepted start; 0 treated as 1.
REQ-010 overlap  input  1  latched on accepted start; 1 = overlapping stream, 0 = full instances separated by gaps.
REQ-011 abort  input  1  terminates an active frame.
REQ-012 data_out  output  1  serial bit stream, registered.
REQ-013 data_valid  output  1  high while data_out carries a pattern bit, registered.
REQ-014 pat_end  output  1  one-cycle pulse coincident with the last bit of each instance, registered.
REQ-015 busy  output  1  high from first emitted bit through last emitted bit or gap, registered.
REQ-016 done  output  1  one-cycle pulse the cycle after the final bit of a completed frame, registered.

Function
REQ-017 FSM states SHALL be IDLE, SEND, GAP, DONE.
REQ-018 IDLE/DONE + start -> SEND; first bit PATTERN[PAT_LEN-1] on data_out the cycle after start is sampled (latency 1).
REQ-019 SEND: one bit per cycle, bit index decrementing; data_valid=1, busy=1.
REQ-020 End of instance with remaining instances, overlap=0, GAP_CYC>0 -> GAP for GAP_CYC cycles, data_out=IDLE_LEVEL, data_valid=0, busy=1; then SEND from bit PAT_LEN-1.
REQ-021 End of instance with remaining instances, overlap=0, GAP_CYC=0 -> SEND directly from bit PAT_LEN-1, no bubble.
REQ-022 End of instance with remaining instances, overlap=1 -> SEND continues at bit index PAT_LEN-1-OVL_LEN with no bubble; instances after the first emit PAT_LEN-OVL_LEN bits.
REQ-023 End of last instance -> DONE for one cycle: done=1, busy=0, data_valid=0, data_out=IDLE_LEVEL; then IDLE unless start is high.
REQ-024 start while busy SHALL be ignored; latched repeat_cnt and overlap SHALL NOT change mid-frame.
REQ-025 abort in SEND or GAP -> IDLE next cycle: data_out=IDLE_LEVEL, data_valid=0, busy=0, no done, no pat_end; abort has priority over frame completion in the same cycle.
REQ-026 abort in IDLE/DONE SHALL be ignored; abort and start in the same IDLE cycle -> start ignored.
REQ-027 Instance counter SHALL be 8 bits; repeat_cnt=255 emits exactly 255 instances with no wrap.
REQ-028 Total valid bits per frame = PAT_LEN + (N-1)*(PAT_LEN-OVL_LEN) when overlap=1, N*PAT_LEN when overlap=0.

Reset
REQ-029 rst_n low at a clock edge SHALL force IDLE, data_out=IDLE_LEVEL, data_valid=0, pat_end=0, busy=0, done=0, all counters 0.
REQ-030 Reset mid-frame SHALL discard the frame with no done pulse; first start after release behaves as from power-up.

Structure
REQ-031 Package seq_gen_pkg SHALL hold the FSM state typedef and default PATTERN/PAT_LEN/OVL_LEN constants.
REQ-032 Single module, no sub-modules; bit index, gap and instance counters inline.

Verification
REQ-033 start, repeat_cnt=1, overlap=0 -> data_out 1,0,0,1,0 with data_valid=1 on cycles 1-5, pat_end on cycle 5, done on cycle 6.
REQ-034 repeat_cnt=2, overlap=0, GAP_CYC=1 -> 1,0,0,1,0,[gap 0, valid=0],1,0,0,1,0; busy high 11 cycles; two pat_end pulses.
REQ-035 repeat_cnt=3, overlap=1 -> 11 contiguous valid bits 1,0,0,1,0,0,1,0,0,1,0; pat_end on bits 5, 8, 11.
REQ-036 repeat_cnt=0 -> identical to repeat_cnt=1; start held high through frame -> exactly one frame, then a second frame beginning the cycle after done.
REQ-037 abort on bit 3 of instance 2 -> IDLE next cycle, data_valid=0, no done; new start then emits a clean full frame.
REQ-038 rst_n low for one cycle mid-GAP -> all outputs at reset values next cycle, no done.
